// File: rtl/airi5c_regfile_pkg.sv
// Shared constants for the parametrised integer register file.
package airi5c_regfile_pkg;

  // Sequencer states: the array is filled in INIT, normal operation in RUN
  localparam logic [0:0] ST_INIT = 1'b0;
  localparam logic [0:0] ST_RUN  = 1'b1;

  // Register i comes out of init holding INIT_BASE + i
  localparam logic [31:0] INIT_BASE_DEFAULT = 32'hdeadbe00;

  // Register address width for a given register count
  function automatic int addr_width(input int nregs);
    return $clog2(nregs);
  endfunction

endpackage

// File: rtl/airi5c_regfile_rdport.sv
// One core read port: x0 forced to zero, pending-buffer forward, optional write bypass.
module airi5c_regfile_rdport
  import airi5c_regfile_pkg::*;
#(
  parameter int XLEN   = 32,
  parameter int AW     = 5,
  parameter int BYPASS = 1
) (
  input  logic [AW-1:0]   ra,
  input  logic [XLEN-1:0] arr_d,
  input  logic            p0_v,
  input  logic [AW-1:0]   p0_a,
  input  logic [XLEN-1:0] p0_d,
  input  logic            p1_v,
  input  logic [AW-1:0]   p1_a,
  input  logic [XLEN-1:0] p1_d,
  input  logic            b0_v,
  input  logic [AW-1:0]   b0_a,
  input  logic [XLEN-1:0] b0_d,
  input  logic            b1_v,
  input  logic [AW-1:0]   b1_a,
  input  logic [XLEN-1:0] b1_d,
  output logic [XLEN-1:0] rd
);

  // Newest value wins: pending buffer, then same-cycle commit, then the array
  always_comb begin
    rd = arr_d;
    if (ra == '0)
      rd = '0;
    else if (p0_v && (p0_a == ra))
      rd = p0_d;
    else if (p1_v && (p1_a == ra))
      rd = p1_d;
    else if ((BYPASS != 0) && b0_v && (b0_a == ra))
      rd = b0_d;
    else if ((BYPASS != 0) && b1_v && (b1_a == ra))
      rd = b1_d;
  end

endmodule

// File: rtl/airi5c_regfile_param.sv
// Parametrised register file with init sequencer, pending write buffer and bypass.
module airi5c_regfile_param
  import airi5c_regfile_pkg::*;
#(
  parameter int          XLEN      = 32,
  parameter int          NREGS     = 32,
  parameter int          AW        = addr_width(NREGS),
  parameter int          NRPORTS   = 3,
  parameter int          BYPASS    = 1,
  parameter logic [31:0] INIT_BASE = INIT_BASE_DEFAULT
) (
  input  logic                    clk_i,
  input  logic                    rst_ni,
  output logic                    init_busy_o,
  input  logic [NRPORTS*AW-1:0]   ra_i,
  output logic [NRPORTS*XLEN-1:0] rd_o,
  input  logic                    wen_i,
  output logic                    wready_o,
  input  logic [AW-1:0]           wa_i,
  input  logic [XLEN-1:0]         wd_i,
  input  logic [XLEN-1:0]         wd2_i,
  input  logic                    use_rd64_i,
  output logic                    illegal_o,
  input  logic [AW-1:0]           dm_wara_i,
  input  logic [XLEN-1:0]         dm_wd_i,
  input  logic                    dm_wen_i,
  output logic [XLEN-1:0]         dm_rd_o
);

  logic [XLEN-1:0] regs [NREGS];

  logic [0:0]      state;
  logic [AW-1:0]   cnt;
  logic            pend_v;
  logic [AW-1:0]   pend_a;
  logic [XLEN-1:0] pend_d;
  logic [XLEN-1:0] pend_d2;
  logic            pend_pair;

  logic            accept;
  logic            core_commit;
  logic            core_lo_en;
  logic            core_hi_en;
  logic [AW-1:0]   core_hi_a;
  logic            pend_lo_en;
  logic            pend_hi_en;
  logic [AW-1:0]   pend_hi_a;

  logic            w0_en;
  logic [AW-1:0]   w0_a;
  logic [XLEN-1:0] w0_d;
  logic            w1_en;
  logic [AW-1:0]   w1_a;
  logic [XLEN-1:0] w1_d;

  assign init_busy_o = (state == ST_INIT);
  assign wready_o    = (state == ST_RUN) && !pend_v;
  assign accept      = wen_i && wready_o;
  assign core_commit = accept && !dm_wen_i;

  // A pair to an odd address writes nothing; the high half of a legal pair is addr|1
  assign core_lo_en = !use_rd64_i || !wa_i[0];
  assign core_hi_en = use_rd64_i && !wa_i[0];
  assign core_hi_a  = {wa_i[AW-1:1], 1'b1};
  assign pend_lo_en = !pend_pair || !pend_a[0];
  assign pend_hi_en = pend_pair && !pend_a[0];
  assign pend_hi_a  = {pend_a[AW-1:1], 1'b1};

  // Select at most one write source per cycle; x0 writes are dropped here
  always_comb begin
    w0_en = 1'b0;
    w0_a  = '0;
    w0_d  = '0;
    w1_en = 1'b0;
    w1_a  = '0;
    w1_d  = '0;
    if (!rst_ni) begin
      w0_en = 1'b0;
    end else if (state == ST_INIT) begin
      w0_en = 1'b1;
      w0_a  = cnt;
      w0_d  = XLEN'(INIT_BASE) + XLEN'(cnt);
    end else if (dm_wen_i) begin
      w0_en = 1'b1;
      w0_a  = dm_wara_i;
      w0_d  = dm_wd_i;
    end else if (pend_v) begin
      w0_en = pend_lo_en;
      w0_a  = pend_a;
      w0_d  = pend_d;
      w1_en = pend_hi_en;
      w1_a  = pend_hi_a;
      w1_d  = pend_d2;
    end else if (accept) begin
      w0_en = core_lo_en;
      w0_a  = wa_i;
      w0_d  = wd_i;
      w1_en = core_hi_en;
      w1_a  = core_hi_a;
      w1_d  = wd2_i;
    end
    if (w0_a == '0) w0_en = 1'b0;
    if (w1_a == '0) w1_en = 1'b0;
  end

  // Array update; no reset so the storage can map onto RAM
  always_ff @(posedge clk_i) begin
    if (w0_en) regs[w0_a] <= w0_d;
    if (w1_en) regs[w1_a] <= w1_d;
  end

  // Sequencer, pending buffer and illegal-pair pulse
  always_ff @(posedge clk_i) begin
    if (!rst_ni) begin
      state     <= ST_INIT;
      cnt       <= AW'(1);
      pend_v    <= 1'b0;
      illegal_o <= 1'b0;
    end else begin
      illegal_o <= accept && use_rd64_i && wa_i[0];
      if (state == ST_INIT) begin
        cnt <= cnt + AW'(1);
        if (cnt == AW'(NREGS - 1)) state <= ST_RUN;
      end else if (pend_v) begin
        if (!dm_wen_i) pend_v <= 1'b0;
      end else if (accept && dm_wen_i) begin
        pend_v    <= 1'b1;
        pend_a    <= wa_i;
        pend_d    <= wd_i;
        pend_d2   <= wd2_i;
        pend_pair <= use_rd64_i;
      end
    end
  end

  assign dm_rd_o = (dm_wara_i == '0) ? '0 : regs[dm_wara_i];

  for (genvar k = 0; k < NRPORTS; k++) begin : g_rd
    logic [XLEN-1:0] arr_d;
    assign arr_d = regs[ra_i[k*AW +: AW]];

    airi5c_regfile_rdport #(
      .XLEN   (XLEN),
      .AW     (AW),
      .BYPASS (BYPASS)
    ) u_rdport (
      .ra    (ra_i[k*AW +: AW]),
      .arr_d (arr_d),
      .p0_v  (pend_v && pend_lo_en),
      .p0_a  (pend_a),
      .p0_d  (pend_d),
      .p1_v  (pend_v && pend_hi_en),
      .p1_a  (pend_hi_a),
      .p1_d  (pend_d2),
      .b0_v  (core_commit && core_lo_en),
      .b0_a  (wa_i),
      .b0_d  (wd_i),
      .b1_v  (core_commit && core_hi_en),
      .b1_a  (core_hi_a),
      .b1_d  (wd2_i),
      .rd    (rd_o[k*XLEN +: XLEN])
    );
  end

endmodule

// File: tb/tb_airi5c_regfile_param.sv
// Directed self-checking bench for airi5c_regfile_param (XLEN=32, NREGS=32, 3 ports).
module tb_airi5c_regfile_param;

  logic        clk_i = 1'b0;
  logic        rst_ni;
  logic        init_busy_o;
  logic [14:0] ra_i;
  logic [95:0] rd_o;
  logic        wen_i;
  logic        wready_o;
  logic [4:0]  wa_i;
  logic [31:0] wd_i;
  logic [31:0] wd2_i;
  logic        use_rd64_i;
  logic        illegal_o;
  logic [4:0]  dm_wara_i;
  logic [31:0] dm_wd_i;
  logic        dm_wen_i;
  logic [31:0] dm_rd_o;

  int tests = 0;
  int fails = 0;
  int n;

  airi5c_regfile_param dut (
    .clk_i       (clk_i),
    .rst_ni      (rst_ni),
    .init_busy_o (init_busy_o),
    .ra_i        (ra_i),
    .rd_o        (rd_o),
    .wen_i       (wen_i),
    .wready_o    (wready_o),
    .wa_i        (wa_i),
    .wd_i        (wd_i),
    .wd2_i       (wd2_i),
    .use_rd64_i  (use_rd64_i),
    .illegal_o   (illegal_o),
    .dm_wara_i   (dm_wara_i),
    .dm_wd_i     (dm_wd_i),
    .dm_wen_i    (dm_wen_i),
    .dm_rd_o     (dm_rd_o)
  );

  always #5 clk_i = ~clk_i;

  // Advance past the next rising edge
  task automatic tick();
    @(posedge clk_i);
    #1;
  endtask

  // Compare one observed value against its expected value
  task automatic check_output(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    tests++;
    assert (obs === exp)
    else begin
      fails++;
      $error("[TB] FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  task automatic set_ra(input logic [4:0] a0, input logic [4:0] a1, input logic [4:0] a2);
    ra_i = {a2, a1, a0};
  endtask

  function automatic logic [31:0] rd(input int k);
    return rd_o[k*32 +: 32];
  endfunction

  // Count cycles with init_busy_o high, bounded
  task automatic count_busy(output int cycles);
    cycles = 0;
    while (init_busy_o === 1'b1 && cycles < 200) begin
      cycles++;
      tick();
    end
  endtask

  task automatic apply_core(input logic [4:0] a, input logic [31:0] d, input logic [31:0] d2, input logic pair);
    wen_i = 1'b1; wa_i = a; wd_i = d; wd2_i = d2; use_rd64_i = pair;
  endtask

  task automatic idle_core();
    wen_i = 1'b0; use_rd64_i = 1'b0;
  endtask

  initial begin
    rst_ni = 1'b0; ra_i = '0; wen_i = 1'b0; wa_i = '0; wd_i = '0; wd2_i = '0;
    use_rd64_i = 1'b0; dm_wara_i = '0; dm_wd_i = '0; dm_wen_i = 1'b0;

    // Reset and init sequence
    tick();
    check_output("reset_busy", 32'(init_busy_o), 32'd1);
    check_output("reset_wready", 32'(wready_o), 32'd0);
    check_output("reset_illegal", 32'(illegal_o), 32'd0);
    rst_ni = 1'b1;
    count_busy(n);
    check_output("init_len", 32'(n), 32'd31);
    set_ra(5'd5, 5'd0, 5'd31); dm_wara_i = 5'd5; #1;
    check_output("init_r5", rd(0), 32'hdeadbe05);
    check_output("init_x0", rd(1), 32'h0);
    check_output("init_r31", rd(2), 32'hdeadbe1f);
    check_output("init_dm_r5", dm_rd_o, 32'hdeadbe05);
    check_output("run_wready", 32'(wready_o), 32'd1);

    // Single write with bypass
    apply_core(5'd7, 32'h1234, 32'h0, 1'b0); set_ra(5'd7, 5'd0, 5'd0); dm_wara_i = 5'd7; #1;
    check_output("bypass_rd0", rd(0), 32'h1234);
    check_output("bypass_dm_old", dm_rd_o, 32'hdeadbe07);
    tick(); idle_core(); #1;
    check_output("wr7_array", rd(0), 32'h1234);
    check_output("wr7_dm", dm_rd_o, 32'h1234);

    // Legal pair, then illegal odd pair
    apply_core(5'd10, 32'hA, 32'hB, 1'b1); set_ra(5'd10, 5'd11, 5'd0); #1;
    check_output("pair_byp_lo", rd(0), 32'hA);
    check_output("pair_byp_hi", rd(1), 32'hB);
    tick(); idle_core(); #1;
    check_output("pair_lo", rd(0), 32'hA);
    check_output("pair_hi", rd(1), 32'hB);
    check_output("pair_no_illegal", 32'(illegal_o), 32'd0);
    apply_core(5'd11, 32'h55, 32'h66, 1'b1); set_ra(5'd10, 5'd11, 5'd12); #1;
    check_output("odd_accepted", 32'(wready_o), 32'd1);
    check_output("odd_no_bypass", rd(1), 32'hB);
    tick(); idle_core(); #1;
    check_output("odd_illegal", 32'(illegal_o), 32'd1);
    check_output("odd_r10", rd(0), 32'hA);
    check_output("odd_r11", rd(1), 32'hB);
    check_output("odd_r12", rd(2), 32'hdeadbe0c);
    tick();
    check_output("odd_illegal_drop", 32'(illegal_o), 32'd0);

    // Core write colliding with debug write
    apply_core(5'd3, 32'h3333, 32'h0, 1'b0);
    dm_wen_i = 1'b1; dm_wara_i = 5'd4; dm_wd_i = 32'h4444; set_ra(5'd3, 5'd4, 5'd0); #1;
    check_output("coll_no_bypass", rd(0), 32'hdeadbe03);
    tick(); idle_core(); #1;
    check_output("coll_wready0", 32'(wready_o), 32'd0);
    check_output("coll_pend_fwd", rd(0), 32'h3333);
    check_output("coll_dm_r4", dm_rd_o, 32'h4444);
    tick(); tick();
    dm_wen_i = 1'b0; dm_wara_i = 5'd3; #1;
    check_output("coll_wready_hold", 32'(wready_o), 32'd0);
    check_output("coll_pend_fwd2", rd(0), 32'h3333);
    check_output("coll_r3_old", dm_rd_o, 32'hdeadbe03);
    tick();
    check_output("coll_wready1", 32'(wready_o), 32'd1);
    check_output("coll_r3_new", dm_rd_o, 32'h3333);
    check_output("coll_r4", rd(1), 32'h4444);

    // Debug and core target the same register: pending write lands last
    apply_core(5'd6, 32'h6666, 32'h0, 1'b0);
    dm_wen_i = 1'b1; dm_wara_i = 5'd6; dm_wd_i = 32'hd6d6; set_ra(5'd6, 5'd0, 5'd0);
    tick(); idle_core(); dm_wen_i = 1'b0; #1;
    check_output("same_dm_first", dm_rd_o, 32'hd6d6);
    check_output("same_pend_fwd", rd(0), 32'h6666);
    tick();
    check_output("same_pend_last", dm_rd_o, 32'h6666);

    // x0 stays zero through core, pair and debug writes
    apply_core(5'd0, 32'hFFFF, 32'h1111, 1'b1); set_ra(5'd0, 5'd0, 5'd1); #1;
    check_output("x0_byp", rd(0), 32'h0);
    tick(); idle_core();
    dm_wen_i = 1'b1; dm_wara_i = 5'd0; dm_wd_i = 32'hFFFF;
    tick(); dm_wen_i = 1'b0; #1;
    check_output("x0_p0", rd(0), 32'h0);
    check_output("x0_p1", rd(1), 32'h0);
    check_output("x0_dm", dm_rd_o, 32'h0);
    check_output("x0_pair_hi", rd(2), 32'h1111);

    // Top pair (30, 31)
    apply_core(5'd30, 32'h30, 32'h31, 1'b1); set_ra(5'd30, 5'd31, 5'd1);
    tick(); idle_core(); #1;
    check_output("top_pair_lo", rd(0), 32'h30);
    check_output("top_pair_hi", rd(1), 32'h31);

    // Reset mid-INIT at cnt=12
    apply_core(5'd5, 32'h5555, 32'h0, 1'b0); tick(); idle_core();
    rst_ni = 1'b0; tick(); rst_ni = 1'b1;
    for (int i = 0; i < 11; i++) tick();
    dm_wara_i = 5'd5; apply_core(5'd9, 32'h7777, 32'h0, 1'b0); #1;
    check_output("midinit_busy", 32'(init_busy_o), 32'd1);
    check_output("midinit_wready", 32'(wready_o), 32'd0);
    check_output("midinit_r5", dm_rd_o, 32'hdeadbe05);
    idle_core();
    rst_ni = 1'b0; tick(); rst_ni = 1'b1;
    count_busy(n);
    check_output("midinit_restart_len", 32'(n), 32'd31);

    // Reset in RUN with a pending write
    apply_core(5'd9, 32'h9999, 32'h0, 1'b0);
    dm_wen_i = 1'b1; dm_wara_i = 5'd8; dm_wd_i = 32'h8888;
    tick(); idle_core(); dm_wen_i = 1'b0; rst_ni = 1'b0; set_ra(5'd9, 5'd8, 5'd0); #1;
    check_output("runrst_pend_fwd", rd(0), 32'h9999);
    tick(); rst_ni = 1'b1; #1;
    check_output("runrst_busy", 32'(init_busy_o), 32'd1);
    check_output("runrst_wready", 32'(wready_o), 32'd0);
    check_output("runrst_pend_lost", rd(0), 32'hdeadbe09);
    for (int i = 0; i < 5; i++) tick();
    dm_wen_i = 1'b1; dm_wara_i = 5'd2; dm_wd_i = 32'h2222;
    tick(); dm_wen_i = 1'b0;
    count_busy(n);
    check_output("runrst_len", 32'(n + 6), 32'd31);
    #1;
    check_output("runrst_r8", rd(1), 32'hdeadbe08);
    check_output("init_dm_ignored", dm_rd_o, 32'hdeadbe02);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
